// File: rtl/max7219_init_arbiter.sv
// Power-up sequencer for a MAX7219 daisy chain: sends the init table through the shared
// serializer, then hands the serializer to the user command source as a transparent mux.
module max7219_init_arbiter #(
    parameter int unsigned G_NB_MATRIX   = 8,
    parameter bit          G_AUTO_INIT   = 1'b1,
    parameter logic [7:0]  G_DECODE_MODE = 8'h00,
    parameter logic [7:0]  G_INTENSITY   = 8'h07,
    parameter logic [7:0]  G_SCAN_LIMIT  = 8'h07
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_init_start,
    output logic        o_init_busy,
    output logic        o_init_done,
    input  logic        i_usr_start,
    input  logic        i_usr_en_load,
    input  logic [15:0] i_usr_data,
    output logic        o_usr_done,
    output logic        o_max7219_if_start,
    output logic        o_max7219_if_en_load,
    output logic [15:0] o_max7219_if_data,
    input  logic        i_max7219_if_done
);

    localparam logic [3:0] LastWord   = 4'd12;
    localparam logic [7:0] LastMatrix = 8'(G_NB_MATRIX - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitDone,
        StNext,
        StGrant
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  word_q, word_d;
    logic [7:0]  mtx_q, mtx_d;
    logic        pending_q, pending_d;
    logic        usr_busy_q, usr_busy_d;
    logic        armed_q;
    logic [15:0] init_word;
    logic        last_copy;
    logic        handover;

    // Rows 1..8 occupy word indices 4..11; indices above 12 are unreachable.
    always_comb begin
        init_word = 16'h0000;
        case (word_q)
            4'd0:    init_word = 16'h0F00;
            4'd1:    init_word = {8'h09, G_DECODE_MODE};
            4'd2:    init_word = {8'h0A, G_INTENSITY};
            4'd3:    init_word = {8'h0B, G_SCAN_LIMIT};
            4'd12:   init_word = 16'h0C01;
            default: init_word = {4'h0, word_q - 4'd3, 8'h00};
        endcase
    end

    assign last_copy = (mtx_q == LastMatrix);

    // A re-init waits for any forwarded user transfer; a user start on the same cycle wins.
    assign handover = pending_q && !i_usr_start && (!usr_busy_q || i_max7219_if_done);

    always_comb begin
        state_d              = state_q;
        word_d               = word_q;
        mtx_d                = mtx_q;
        pending_d            = pending_q;
        usr_busy_d           = usr_busy_q;
        o_init_busy          = 1'b0;
        o_init_done          = 1'b0;
        o_usr_done           = 1'b0;
        o_max7219_if_start   = 1'b0;
        o_max7219_if_en_load = 1'b0;
        o_max7219_if_data    = 16'h0000;

        case (state_q)
            StIdle: begin
                if (i_init_start || (G_AUTO_INIT && armed_q)) begin
                    state_d = StLoad;
                    word_d  = 4'd0;
                    mtx_d   = 8'd0;
                end
            end
            StLoad: begin
                o_init_busy          = 1'b1;
                o_max7219_if_data    = init_word;
                o_max7219_if_en_load = last_copy;
                state_d              = StStart;
            end
            StStart: begin
                o_init_busy          = 1'b1;
                o_max7219_if_start   = 1'b1;
                o_max7219_if_data    = init_word;
                o_max7219_if_en_load = last_copy;
                state_d              = StWaitDone;
            end
            StWaitDone: begin
                o_init_busy          = 1'b1;
                o_max7219_if_data    = init_word;
                o_max7219_if_en_load = last_copy;
                if (i_max7219_if_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                o_init_busy          = 1'b1;
                o_max7219_if_data    = init_word;
                o_max7219_if_en_load = last_copy;
                if (last_copy) begin
                    mtx_d = 8'd0;
                    if (word_q == LastWord) begin
                        state_d    = StGrant;
                        pending_d  = 1'b0;
                        usr_busy_d = 1'b0;
                    end else begin
                        word_d  = word_q + 4'd1;
                        state_d = StLoad;
                    end
                end else begin
                    mtx_d   = mtx_q + 8'd1;
                    state_d = StLoad;
                end
            end
            StGrant: begin
                o_init_done          = 1'b1;
                o_max7219_if_start   = i_usr_start;
                o_max7219_if_en_load = i_usr_en_load;
                o_max7219_if_data    = i_usr_data;
                o_usr_done           = i_max7219_if_done;
                if (i_usr_start) begin
                    usr_busy_d = 1'b1;
                end else if (i_max7219_if_done) begin
                    usr_busy_d = 1'b0;
                end
                if (i_init_start) begin
                    pending_d = 1'b1;
                end
                if (handover) begin
                    state_d    = StLoad;
                    word_d     = 4'd0;
                    mtx_d      = 8'd0;
                    pending_d  = 1'b0;
                    usr_busy_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // armed_q delays auto-init by one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_q     <= 4'd0;
            mtx_q      <= 8'd0;
            pending_q  <= 1'b0;
            usr_busy_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            mtx_q      <= mtx_d;
            pending_q  <= pending_d;
            usr_busy_q <= usr_busy_d;
            armed_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_max7219_init_arbiter.sv
// Randomized bench for max7219_init_arbiter: two instances (default auto-init chain of 8,
// and a single manual-init device with custom register values) against a serializer model.
module tb_max7219_init_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        a_rst_n, a_init_start, a_init_busy, a_init_done;
    logic        a_usr_start, a_usr_en_load, a_usr_done;
    logic [15:0] a_usr_data, a_if_data;
    logic        a_if_start, a_if_en_load, a_if_done;

    logic        b_rst_n, b_init_start, b_init_busy, b_init_done;
    logic        b_usr_start, b_usr_en_load, b_usr_done;
    logic [15:0] b_usr_data, b_if_data;
    logic        b_if_start, b_if_en_load, b_if_done;

    max7219_init_arbiter dut_a (
        .clk                  (clk),
        .rst_n                (a_rst_n),
        .i_init_start         (a_init_start),
        .o_init_busy          (a_init_busy),
        .o_init_done          (a_init_done),
        .i_usr_start          (a_usr_start),
        .i_usr_en_load        (a_usr_en_load),
        .i_usr_data           (a_usr_data),
        .o_usr_done           (a_usr_done),
        .o_max7219_if_start   (a_if_start),
        .o_max7219_if_en_load (a_if_en_load),
        .o_max7219_if_data    (a_if_data),
        .i_max7219_if_done    (a_if_done)
    );

    max7219_init_arbiter #(
        .G_NB_MATRIX   (1),
        .G_AUTO_INIT   (1'b0),
        .G_DECODE_MODE (8'hFF),
        .G_INTENSITY   (8'h0F),
        .G_SCAN_LIMIT  (8'h03)
    ) dut_b (
        .clk                  (clk),
        .rst_n                (b_rst_n),
        .i_init_start         (b_init_start),
        .o_init_busy          (b_init_busy),
        .o_init_done          (b_init_done),
        .i_usr_start          (b_usr_start),
        .i_usr_en_load        (b_usr_en_load),
        .i_usr_data           (b_usr_data),
        .o_usr_done           (b_usr_done),
        .o_max7219_if_start   (b_if_start),
        .o_max7219_if_en_load (b_if_en_load),
        .o_max7219_if_data    (b_if_data),
        .i_max7219_if_done    (b_if_done)
    );

    // Captured serializer traffic: word, en_load, start cycle; and done cycles.
    logic [15:0] a_qd[$];
    logic        a_qe[$];
    int unsigned a_qc[$];
    int unsigned a_dc[$];
    int          a_lat = 0;
    int          a_unstable = 0;
    int          a_bad_udone = 0;

    logic [15:0] b_qd[$];
    logic        b_qe[$];
    int          b_unstable = 0;
    int          b_bad_udone = 0;

    initial begin : model_a
        int cnt;
        logic [15:0] held_d;
        logic held_e;
        cnt = 0;
        held_d = 16'h0;
        held_e = 1'b0;
        a_if_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!a_rst_n) begin
                cnt = 0;
            end else if (a_if_start) begin
                a_qd.push_back(a_if_data);
                a_qe.push_back(a_if_en_load);
                a_qc.push_back(cyc);
                held_d = a_if_data;
                held_e = a_if_en_load;
                cnt = (a_lat == 0) ? int'($urandom_range(25, 1)) : a_lat;
            end else if (cnt > 0 && a_init_busy &&
                         (a_if_data !== held_d || a_if_en_load !== held_e)) begin
                a_unstable++;
            end
            if (a_rst_n && a_init_busy && a_usr_done) a_bad_udone++;
            @(posedge clk);
            #1;
            a_if_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    a_if_done = 1'b1;
                    a_dc.push_back(cyc);
                end
            end
        end
    end

    initial begin : model_b
        int cnt;
        logic [15:0] held_d;
        logic held_e;
        cnt = 0;
        held_d = 16'h0;
        held_e = 1'b0;
        b_if_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!b_rst_n) begin
                cnt = 0;
            end else if (b_if_start) begin
                b_qd.push_back(b_if_data);
                b_qe.push_back(b_if_en_load);
                held_d = b_if_data;
                held_e = b_if_en_load;
                cnt = int'($urandom_range(6, 1));
            end else if (cnt > 0 && b_init_busy &&
                         (b_if_data !== held_d || b_if_en_load !== held_e)) begin
                b_unstable++;
            end
            if (b_rst_n && b_init_busy && b_usr_done) b_bad_udone++;
            @(posedge clk);
            #1;
            b_if_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) b_if_done = 1'b1;
            end
        end
    end

    function automatic logic [15:0] ref_word(input int w, input logic [7:0] dec,
                                             input logic [7:0] inten, input logic [7:0] scan);
        logic [15:0] tbl[13];
        tbl[0] = 16'h0F00;
        tbl[1] = {8'h09, dec};
        tbl[2] = {8'h0A, inten};
        tbl[3] = {8'h0B, scan};
        for (int r = 1; r <= 8; r++) tbl[3 + r] = {8'(r), 8'h00};
        tbl[12] = 16'h0C01;
        return tbl[w];
    endfunction

    // Transfer t carries word t/n; only the last copy of each word (t%n == n-1) loads.
    function automatic int seq_errs(input logic [15:0] qd[$], input logic qe[$], input int n,
                                    input logic [7:0] dec, input logic [7:0] inten,
                                    input logic [7:0] scan);
        int e = 0;
        if (qd.size() != 13 * n || qe.size() != 13 * n) return 1000;
        for (int t = 0; t < 13 * n; t++) begin
            if (qd[t] !== ref_word(t / n, dec, inten, scan) || qe[t] !== ((t % n) == (n - 1)))
                e++;
        end
        return e;
    endfunction

    function automatic int count_en(input logic qe[$]);
        int c = 0;
        foreach (qe[i]) if (qe[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic wait_a_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_init_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({a_init_busy, a_init_done, a_usr_done, a_if_start, a_if_en_load, a_if_data} !== '0) begin
            errors++;
            $display("FAIL reset_a: outputs=%h expected 0",
                     {a_init_busy, a_init_done, a_usr_done, a_if_start, a_if_en_load, a_if_data});
        end
        checks++;
        if ({b_init_busy, b_init_done, b_usr_done, b_if_start, b_if_en_load, b_if_data} !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs=%h expected 0",
                     {b_init_busy, b_init_done, b_usr_done, b_if_start, b_if_en_load, b_if_data});
        end
        a_qd.delete(); a_qe.delete(); a_qc.delete(); a_dc.delete();
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_init_busy !== 1'b0 || a_if_start !== 1'b0) begin
            errors++;
            $display("FAIL auto_idle: busy=%b start=%b expected 0 0", a_init_busy, a_if_start);
        end
        @(negedge clk);
        checks++;
        if (a_init_busy !== 1'b1 || a_if_start !== 1'b0) begin
            errors++;
            $display("FAIL auto_load: busy=%b start=%b expected 1 0", a_init_busy, a_if_start);
        end
        @(negedge clk);
        checks++;
        if (a_if_start !== 1'b1 || a_if_data !== 16'h0F00 || a_if_en_load !== 1'b0) begin
            errors++;
            $display("FAIL auto_first_start: start=%b data=%h en=%b expected 1 0f00 0",
                     a_if_start, a_if_data, a_if_en_load);
        end
    endtask

    task automatic test_auto_init();
        bit ok = 1'b0;
        int unsigned rise = 0;
        int gaps = 0;
        a_lat = 0;
        for (int i = 0; i < 3500 && !ok; i++) begin
            @(posedge clk);
            #1;
            a_usr_start   = !a_init_done && ($urandom_range(7, 0) == 0);
            a_usr_data    = 16'($urandom);
            a_usr_en_load = 1'($urandom);
            @(negedge clk);
            if (a_init_done) begin
                ok = 1'b1;
                rise = cyc;
            end
        end
        a_usr_start = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL auto_grant: init_done never rose within budget");
        end
        checks++;
        if (a_qd.size() != 104) begin
            errors++;
            $display("FAIL auto_start_count: got %0d expected 104", a_qd.size());
        end
        checks++;
        if (count_en(a_qe) != 13) begin
            errors++;
            $display("FAIL auto_en_count: got %0d expected 13", count_en(a_qe));
        end
        checks++;
        if (seq_errs(a_qd, a_qe, 8, 8'h00, 8'h07, 8'h07) != 0) begin
            errors++;
            $display("FAIL auto_sequence: %0d wrong transfers expected 0",
                     seq_errs(a_qd, a_qe, 8, 8'h00, 8'h07, 8'h07));
        end
        checks++;
        if (a_dc.size() != 104 || rise != a_dc[a_dc.size() - 1] + 2) begin
            errors++;
            $display("FAIL auto_done_latency: done rose cycle %0d, last serializer done cycle %0d, expected +2",
                     rise, (a_dc.size() > 0) ? a_dc[a_dc.size() - 1] : 0);
        end
        for (int i = 1; i < a_qc.size() && i <= a_dc.size(); i++)
            if (a_qc[i] != a_dc[i - 1] + 3) gaps++;
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL auto_done_to_start: %0d gaps differ from 3 cycles expected 0", gaps);
        end
        checks++;
        if (a_unstable != 0 || a_bad_udone != 0 || a_init_busy !== 1'b0) begin
            errors++;
            $display("FAIL auto_hold: unstable=%0d usr_done_during_init=%0d busy=%b expected 0 0 0",
                     a_unstable, a_bad_udone, a_init_busy);
        end
    endtask

    task automatic test_usr_passthrough();
        logic [15:0] d;
        logic e;
        int seen;
        int bad;
        for (int k = 0; k < 5; k++) begin
            d = (k == 0) ? 16'h0355 : 16'($urandom);
            e = (k == 0) ? 1'b1 : 1'($urandom);
            a_lat = (k == 0) ? 20 : 0;
            @(posedge clk);
            #1;
            a_usr_start = 1'b1;
            a_usr_data = d;
            a_usr_en_load = e;
            #1;
            checks++;
            if ({a_if_start, a_if_en_load, a_if_data} !== {1'b1, e, d} || a_init_done !== 1'b1) begin
                errors++;
                $display("FAIL usr_mirror: start=%b en=%b data=%h done=%b expected 1 %b %h 1",
                         a_if_start, a_if_en_load, a_if_data, a_init_done, e, d);
            end
            @(posedge clk);
            #1;
            a_usr_start = 1'b0;
            a_usr_data = 16'($urandom);
            #1;
            checks++;
            if (a_if_start !== 1'b0 || a_if_data !== a_usr_data) begin
                errors++;
                $display("FAIL usr_release: start=%b data=%h expected 0 %h",
                         a_if_start, a_if_data, a_usr_data);
            end
            seen = 0;
            bad = 0;
            for (int i = 0; i < 40 && seen == 0; i++) begin
                @(negedge clk);
                if (a_usr_done !== a_if_done) bad++;
                if (a_if_done) seen++;
            end
            checks++;
            if (seen != 1 || bad != 0) begin
                errors++;
                $display("FAIL usr_done: seen=%0d mismatched_cycles=%0d expected 1 0", seen, bad);
            end
        end
        a_lat = 0;
    endtask

    task automatic test_reinit(input bit usr_first);
        logic [15:0] d;
        bit ok;
        bit seen = 1'b0;
        bit dropped = 1'b0;
        int hold = 0;
        d = 16'($urandom);
        a_qd.delete(); a_qe.delete(); a_qc.delete(); a_dc.delete();
        a_lat = 12;
        if (usr_first) begin
            @(posedge clk); #1;
            a_usr_start = 1'b1; a_usr_data = d; a_usr_en_load = 1'b1;
            @(posedge clk); #1;
            a_usr_start = 1'b0; a_lat = 0;
            repeat (3) @(posedge clk);
            #1;
            a_init_start = 1'b1;
            @(posedge clk); #1;
            a_init_start = 1'b0;
        end else begin
            @(posedge clk); #1;
            a_init_start = 1'b1;
            @(posedge clk); #1;
            a_init_start = 1'b0;
            a_usr_start = 1'b1; a_usr_data = d; a_usr_en_load = 1'b1;
            #1;
            checks++;
            if (a_if_start !== 1'b1 || a_if_data !== d || a_init_done !== 1'b1) begin
                errors++;
                $display("FAIL reinit_race_forward: start=%b data=%h done=%b expected 1 %h 1",
                         a_if_start, a_if_data, a_init_done, d);
            end
            @(posedge clk); #1;
            a_usr_start = 1'b0; a_lat = 0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!a_init_done) hold++;
            if (a_if_done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || hold != 0 || a_usr_done !== 1'b1) begin
            errors++;
            $display("FAIL reinit_hold: done_seen=%b early_drop_cycles=%0d usr_done=%b expected 1 0 1",
                     seen, hold, a_usr_done);
        end
        for (int i = 0; i < 2 && !dropped; i++) begin
            @(negedge clk);
            if (a_init_done === 1'b0 && a_init_busy === 1'b1) dropped = 1'b1;
        end
        checks++;
        if (!dropped) begin
            errors++;
            $display("FAIL reinit_handover: done=%b busy=%b expected 0 1", a_init_done, a_init_busy);
        end
        wait_a_grant(3500, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reinit_grant: init_done never returned within budget");
        end
        checks++;
        if (a_qd.size() == 0 || a_qd[0] !== d) begin
            errors++;
            $display("FAIL reinit_usr_first: first word %h expected %h",
                     (a_qd.size() > 0) ? a_qd[0] : 16'h0, d);
        end
        if (a_qd.size() > 0) begin
            void'(a_qd.pop_front());
            void'(a_qe.pop_front());
        end
        checks++;
        if (seq_errs(a_qd, a_qe, 8, 8'h00, 8'h07, 8'h07) != 0) begin
            errors++;
            $display("FAIL reinit_sequence: %0d wrong transfers (count %0d) expected 0 (104)",
                     seq_errs(a_qd, a_qe, 8, 8'h00, 8'h07, 8'h07), a_qd.size());
        end
    endtask

    task automatic test_reset_midway();
        bit ok = 1'b0;
        a_qd.delete(); a_qe.delete(); a_qc.delete(); a_dc.delete();
        a_lat = 0;
        @(posedge clk); #1;
        a_init_start = 1'b1;
        @(posedge clk); #1;
        a_init_start = 1'b0;
        for (int i = 0; i < 2000 && a_qd.size() < 49; i++) @(negedge clk);
        a_lat = 25;
        for (int i = 0; i < 100 && a_qd.size() < 50; i++) @(negedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (a_qd.size() != 50 || a_init_busy !== 1'b1 || a_if_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset_waitdone: transfers=%0d busy=%b start=%b expected 50 1 0",
                     a_qd.size(), a_init_busy, a_if_start);
        end
        #1;
        a_rst_n = 1'b0;
        #1;
        checks++;
        if ({a_init_busy, a_init_done, a_usr_done, a_if_start, a_if_en_load, a_if_data} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: outputs=%h expected 0",
                     {a_init_busy, a_init_done, a_usr_done, a_if_start, a_if_en_load, a_if_data});
        end
        repeat (2) @(negedge clk);
        a_qd.delete(); a_qe.delete(); a_qc.delete(); a_dc.delete();
        a_lat = 0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        wait_a_grant(3500, ok);
        checks++;
        if (!ok || a_qd.size() == 0 || a_qd[0] !== 16'h0F00 || a_qe[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart: granted=%b first=%h en=%b expected 1 0f00 0",
                     ok, (a_qd.size() > 0) ? a_qd[0] : 16'h0,
                     (a_qe.size() > 0) ? a_qe[0] : 1'b0);
        end
        checks++;
        if (seq_errs(a_qd, a_qe, 8, 8'h00, 8'h07, 8'h07) != 0) begin
            errors++;
            $display("FAIL midreset_sequence: %0d wrong transfers (count %0d) expected 0 (104)",
                     seq_errs(a_qd, a_qe, 8, 8'h00, 8'h07, 8'h07), a_qd.size());
        end
    endtask

    task automatic test_manual_init();
        bit ok = 1'b0;
        bit sent = 1'b0;
        checks++;
        if (b_init_busy !== 1'b0 || b_init_done !== 1'b0 || b_qd.size() != 0) begin
            errors++;
            $display("FAIL manual_no_auto: busy=%b done=%b starts=%0d expected 0 0 0",
                     b_init_busy, b_init_done, b_qd.size());
        end
        @(posedge clk); #1;
        b_init_start = 1'b1;
        @(negedge clk);
        checks++;
        if (b_init_busy !== 1'b0) begin
            errors++;
            $display("FAIL manual_pre: busy=%b expected 0", b_init_busy);
        end
        @(posedge clk); #1;
        b_init_start = 1'b0;
        @(negedge clk);
        checks++;
        if (b_init_busy !== 1'b1 || b_if_start !== 1'b0) begin
            errors++;
            $display("FAIL manual_busy: busy=%b start=%b expected 1 0", b_init_busy, b_if_start);
        end
        @(negedge clk);
        checks++;
        if (b_if_start !== 1'b1 || b_if_data !== 16'h0F00 || b_if_en_load !== 1'b1) begin
            errors++;
            $display("FAIL manual_first: start=%b data=%h en=%b expected 1 0f00 1",
                     b_if_start, b_if_data, b_if_en_load);
        end
        for (int i = 0; i < 600 && !ok; i++) begin
            @(posedge clk);
            #1;
            b_init_start  = (b_qd.size() >= 5) && !sent;
            if (b_init_start) sent = 1'b1;
            b_usr_start   = !b_init_done && ($urandom_range(5, 0) == 0);
            b_usr_data    = 16'($urandom);
            b_usr_en_load = 1'($urandom);
            @(negedge clk);
            if (b_init_done) ok = 1'b1;
        end
        b_init_start = 1'b0;
        b_usr_start = 1'b0;
        checks++;
        if (!ok || b_qd.size() != 13 || count_en(b_qe) != 13) begin
            errors++;
            $display("FAIL manual_counts: granted=%b starts=%0d en_loads=%0d expected 1 13 13",
                     ok, b_qd.size(), count_en(b_qe));
        end
        checks++;
        if (seq_errs(b_qd, b_qe, 1, 8'hFF, 8'h0F, 8'h03) != 0) begin
            errors++;
            $display("FAIL manual_sequence: %0d wrong transfers expected 0",
                     seq_errs(b_qd, b_qe, 1, 8'hFF, 8'h0F, 8'h03));
        end
        checks++;
        if (b_unstable != 0 || b_bad_udone != 0) begin
            errors++;
            $display("FAIL manual_hold: unstable=%0d usr_done_during_init=%0d expected 0 0",
                     b_unstable, b_bad_udone);
        end
    endtask

    initial begin
        a_rst_n = 1'b0; a_init_start = 1'b0; a_usr_start = 1'b0;
        a_usr_en_load = 1'b0; a_usr_data = 16'h0;
        b_rst_n = 1'b0; b_init_start = 1'b0; b_usr_start = 1'b0;
        b_usr_en_load = 1'b0; b_usr_data = 16'h0;
        test_reset();
        test_auto_init();
        test_usr_passthrough();
        test_reinit(1'b1);
        test_reinit(1'b0);
        test_reset_midway();
        test_manual_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/max7219_init_arbiter.md
# max7219_init_arbiter

Sequences the MAX7219 power-up configuration into a daisy chain of G_NB_MATRIX devices through the single max7219_if serializer, then hands that serializer to the user-side command source (max7219_cmd_decod or equivalent). It sits between the command decoders and max7219_if. It owns the serializer handshake during initialisation and is a transparent pass-through once granted.

## Interface
- G_NB_MATRIX, 8, devices in the chain (1..255); each init word is sent this many times.
- G_AUTO_INIT, 1, 1 = start init automatically after reset release; 0 = wait for i_init_start.
- G_DECODE_MODE, 8'h00, value written to register 0x09.
- G_INTENSITY, 8'h07, value written to register 0x0A.
- G_SCAN_LIMIT, 8'h07, value written to register 0x0B.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- i_init_start  in  1  pulse: request (re)initialisation.
- o_init_busy  out  1  high while the init sequence owns the serializer.
- o_init_done  out  1  level: init completed, user granted.
- i_usr_start, i_usr_en_load  in  1  user handshake, same semantics as max7219_if.
- i_usr_data  in  16  user word.
- o_usr_done  out  1  serializer done, forwarded to user.
- o_max7219_if_start  out  1  start pulse to max7219_if.
- o_max7219_if_en_load  out  1  load enable to max7219_if.
- o_max7219_if_data  out  16  word to max7219_if.
- i_max7219_if_done  in  1  one-cycle done pulse from max7219_if.

## Operation
- Init table, 13 words, {addr[7:0], value[7:0]}, in this order:
  - 0x0F00 (display test off)
  - 0x09 G_DECODE_MODE
  - 0x0A G_INTENSITY
  - 0x0B G_SCAN_LIMIT
  - 0x0100 to 0x0800 (digit rows cleared)
  - 0x0C01 (normal operation)
- Each word is sent G_NB_MATRIX times. o_max7219_if_en_load = 1 only on the last copy (matrix counter == G_NB_MATRIX-1).
- Total transfers = 13*G_NB_MATRIX (104 by default).
- FSM states:
  - IDLE: outputs 0. Go to LOAD on i_init_start, or one cycle after reset release if G_AUTO_INIT=1.
  - LOAD: drive data and en_load from the word index and matrix counter.
  - START: o_max7219_if_start=1 for exactly one cycle.
  - WAIT_DONE: hold data and en_load stable until i_max7219_if_done.
  - NEXT: advance the matrix counter. On wrap to 0, advance the word index. After the last transfer go to GRANT, else go to LOAD.
  - GRANT: o_init_done=1. o_max7219_if_* = i_usr_* and o_usr_done = i_max7219_if_done (combinational mux).
- o_init_busy = 1 in LOAD/START/WAIT_DONE/NEXT. o_usr_done = 0 outside GRANT.
- i_usr_start outside GRANT is dropped; no done is ever returned for it.
- i_init_start while busy is ignored.
- i_init_start in GRANT:
  - Latched as pending; o_init_done stays 1 until handover.
  - If a user transfer is in flight (usr_busy set by forwarded i_usr_start, cleared by i_max7219_if_done), wait for its done.
  - Then clear o_init_done and go to LOAD with counters at 0.
  - Simultaneous i_usr_start and pending re-init on the handover cycle: the user start is forwarded and completes first.
- Counters: word index 4 bits (0..12), matrix counter 8 bits; both reset to 0 on each init entry.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, pending flag 0.
- Auto init: rst_n rises before edge r. LOAD at r+1, first start pulse in the cycle after r+1.
- i_init_start sampled at edge k: o_init_busy high from k+1, first o_max7219_if_start in the cycle after k+1.
- Done sampled in WAIT_DONE at edge d: the next start pulse is in cycle d+3 (NEXT, LOAD, START).
- Last done at edge d: o_init_done=1 and o_init_busy=0 from d+2; the first usable user start is in that same cycle.
- Reset mid-sequence: all outputs return to 0 immediately, with no stale start. A done arriving after reset release while in IDLE is ignored.

## Test plan
- Default parameters, G_AUTO_INIT=1, serializer model returns done 20 cycles after start:
  - exactly 104 start pulses and 13 with en_load=1;
  - en_load words in order 0F00,0900,0A07,0B07,0100..0800,0C01;
  - o_init_done rises 2 cycles after the 104th done.
- G_NB_MATRIX=1, G_AUTO_INIT=0, pulse i_init_start: 13 starts, every one with en_load=1; busy high from the cycle after the pulse.
- After grant, user sends start with data 0x0355 and en_load=1: interface outputs mirror the user inputs in the same cycle; o_usr_done pulses with i_max7219_if_done.
- i_usr_start during init: no extra start on the interface; start count stays 104; o_usr_done is never asserted.
- i_init_start while a user transfer is in flight: o_init_done stays 1 until its done, then drops; a new 104-transfer sequence starts with counters at 0.
- rst_n asserted during WAIT_DONE of transfer 50: outputs 0 immediately. With G_AUTO_INIT=1, after release the sequence restarts from word 0x0F00, matrix 0.
